seq_left_rot: RTL and testbench



---
 rtl/seq_left_rot_pkg.sv | 23 ++
 rtl/seq_left_rot_if.sv | 32 +++
 rtl/seq_left_rot_step.sv | 21 ++
 rtl/seq_left_rot.sv | 83 ++++++++
 tb/tb_seq_left_rot.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_left_rot_pkg.sv
// Shared shifter constants and state type for the multi-cycle left rotator.
// Imported by the interface, the step datapath and the top.
package seq_left_rot_pkg;

  localparam int ROT_WIDTH = 16;
  localparam int AMT_WIDTH = 4;
  localparam int BIG_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [ROT_WIDTH-1:0] rot_word_t;
  typedef logic [AMT_WIDTH-1:0] rot_amt_t;

  // Number of rotate steps the sequencer spends on a given amount.
  function automatic int unsigned step_count(rot_amt_t amt);
    return int'(amt) / BIG_STEP + int'(amt) % BIG_STEP;
  endfunction

endpackage

// File: rtl/seq_left_rot_if.sv
// Request/result bundle between a client (ALU or bench) and seq_left_rot.
// The client owns start/operand/amount; the rotator owns result and status.
interface seq_left_rot_if
  import seq_left_rot_pkg::*;
();

  logic      start;
  rot_word_t RL_In;
  rot_amt_t  RL_Amt;
  rot_word_t RL_Out;
  logic      busy;
  logic      done;

  modport master (
    output start,
    output RL_In,
    output RL_Amt,
    input  RL_Out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  RL_In,
    input  RL_Amt,
    output RL_Out,
    output busy,
    output done
  );

endinterface

// File: rtl/seq_left_rot_step.sv
// Combinational single step of the left rotator.
// sel_big picks a rotate-left by BIG_STEP, otherwise rotate-left by one.
module rot_left_step
  import seq_left_rot_pkg::*;
#(
  parameter int W = ROT_WIDTH
) (
  input  logic [W-1:0] din,
  input  logic         sel_big,
  output logic [W-1:0] dout
);

  logic [W-1:0] rot_big;
  logic [W-1:0] rot_one;

  assign rot_big = {din[W-BIG_STEP-1:0], din[W-1:W-BIG_STEP]};
  assign rot_one = {din[W-2:0], din[W-1]};

  assign dout = sel_big ? rot_big : rot_one;

endmodule

// File: rtl/seq_left_rot.sv
// Multi-cycle 16-bit left rotator: 4 bits per cycle while >=4 remain,
// then 1 bit per cycle, with a one-cycle done pulse on completion.
module seq_left_rot
  import seq_left_rot_pkg::*;
#(
  parameter int WIDTH = ROT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_left_rot_if.slave  rl
);

  state_e           state;
  logic [WIDTH-1:0] work;
  rot_amt_t         rem;

  logic             sel_big;
  logic [WIDTH-1:0] step_out;
  rot_amt_t         rem_nxt;

  // Big step is legal only when at least BIG_STEP bits remain.
  assign sel_big = rem >= rot_amt_t'(BIG_STEP);
  assign rem_nxt = sel_big ? rem - rot_amt_t'(BIG_STEP)
                           : rem - rot_amt_t'(1);

  rot_left_step #(
    .W (WIDTH)
  ) u_step (
    .din     (work),
    .sel_big (sel_big),
    .dout    (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rl.start) begin
            work  <= rl.RL_In;
            rem   <= rl.RL_Amt;
            state <= (rl.RL_Amt != '0) ? ROT : DONE;
          end
        end
        ROT: begin
          work <= step_out;
          rem  <= rem_nxt;
          if (rem_nxt == '0)
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rl.RL_Out = work;
  assign rl.busy   = (state == ROT);
  assign rl.done   = (state == DONE);

  a_busy_done_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(rl.busy && rl.done)
  );

  a_rot_has_work: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == ROT) |-> (rem != '0)
  );

  a_done_one_cycle: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == DONE) |=> (state == IDLE)
  );

endmodule

// File: tb/tb_seq_left_rot.sv
// Scoreboard bench for seq_left_rot: directed cases plus a random sweep
// checked against an arithmetic rotate model.
module tb_seq_left_rot;
  import seq_left_rot_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_left_rot_if rl ();

  seq_left_rot dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rl    (rl)
  );

  typedef struct {
    logic [15:0] din;
    logic [3:0]  amt;
    logic [15:0] exp;
    int          acc;
  } item_t;

  item_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rotl_ref(logic [15:0] x, int a);
    int v;
    v = int'(x);
    v = ((v << a) | (v >> (16 - a))) & 32'hFFFF;
    return v[15:0];
  endfunction

  function automatic logic [15:0] rotr_ref(logic [15:0] x, int a);
    return rotl_ref(x, (16 - a) % 16);
  endfunction

  function automatic int steps_ref(int a);
    return a / 4 + a % 4;
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      check("busy_done_excl", {31'd0, rl.busy & rl.done}, 32'd0);
      if (rl.busy) busy_cnt++;
      if (rl.done) begin
        n_done++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done got=1 exp=0 t=%0t", $time);
        end else begin
          it = sb.pop_front();
          check("result", {16'd0, rl.RL_Out}, {16'd0, it.exp});
          check("latency", cyc - it.acc, steps_ref(int'(it.amt)));
          check("busy_cycles", busy_cnt, steps_ref(int'(it.amt)));
          check("rotr_inverse", {16'd0, rotr_ref(rl.RL_Out, int'(it.amt))},
                {16'd0, it.din});
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((rl.busy || rl.done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout got=%0d exp=<50", t);
    end
  endtask

  task automatic issue(input logic [15:0] din, input logic [3:0] amt,
                       input logic [15:0] exp, input bit track);
    wait_idle();
    rl.RL_In  = din;
    rl.RL_Amt = amt;
    rl.start  = 1'b1;
    if (track) begin
      sb.push_back('{din, amt, exp, cyc + 1});
      n_acc++;
    end
    @(negedge clk);
    rl.start  = 1'b0;
    rl.RL_In  = 16'($urandom);
    rl.RL_Amt = 4'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || rl.busy || rl.done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout got=%0d exp=<100", sb.size());
    end
  endtask

  initial begin
    logic [15:0] d;
    int t;
    rl.start  = 1'b0;
    rl.RL_In  = 16'h0;
    rl.RL_Amt = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_out", {16'd0, rl.RL_Out}, 32'd0);
    check("rst_busy", {31'd0, rl.busy}, 32'd0);
    check("rst_done", {31'd0, rl.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'hEC21, 4'd0, 16'hEC21, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("hold_amt0", {16'd0, rl.RL_Out}, 32'h0000EC21);

    issue(16'h9F0A, 4'd4, 16'hF0A9, 1'b1);
    drain();
    issue(16'hC2E5, 4'd7, 16'h72E1, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    check("hold_amt7", {16'd0, rl.RL_Out}, 32'h000072E1);

    // Starts landing on E2 and in the DONE cycle must be dropped.
    issue(16'hF0F0, 4'd15, 16'h7878, 1'b1);
    @(negedge clk);
    rl.RL_In  = 16'h1234;
    rl.RL_Amt = 4'd1;
    rl.start  = 1'b1;
    @(negedge clk);
    rl.start  = 1'b0;
    t = 0;
    while (!rl.done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("f0f0_done_seen", {31'd0, rl.done}, 32'd1);
    rl.RL_In  = 16'hAAAA;
    rl.RL_Amt = 4'd2;
    rl.start  = 1'b1;
    @(negedge clk);
    rl.start  = 1'b0;
    repeat (4) @(negedge clk);
    check("ignored_start_out", {16'd0, rl.RL_Out}, 32'h00007878);
    check("ignored_start_busy", {31'd0, rl.busy}, 32'd0);

    // Reset in the middle of an amount-11 op abandons it silently.
    issue(16'h5A3C, 4'd11, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out", {16'd0, rl.RL_Out}, 32'd0);
    check("midrst_busy", {31'd0, rl.busy}, 32'd0);
    check("midrst_done", {31'd0, rl.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_done", n_done, n_acc);
    issue(16'h0001, 4'd1, 16'h0002, 1'b1);
    drain();
    check("post_rst_out", {16'd0, rl.RL_Out}, 32'h00000002);

    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < 200; k++) begin
        d = 16'($urandom);
        issue(d, 4'(a), rotl_ref(d, a), 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();
    check("done_count", n_done, n_acc);
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
